hazard_ctrl: RTL and testbench

// Pipeline hazard controller for the 5-stage CPU; sits beside the forwarding unit and

---
 rtl/hazard_ctrl.sv | 117 +++++++++++
 tb/tb_hazard_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline.
// Load-use stall, MUL/DIV freeze, branch flush, stall counter.
module hazard_ctrl #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic             ex_md_start,
  input  logic             ex_branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic             exmem_bubble,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic {
    RUN,
    MD_BUSY
  } state_t;

  localparam logic [3:0] MD_INIT = 4'(MD_LATENCY - 2);

  state_t     state;
  logic [3:0] md_cnt;
  logic       load_use;

  assign load_use = idex_memread && (idex_rt != 5'd0) &&
                    ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

  // Mealy control outputs from state and hazard inputs
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    md_busy      = (state == MD_BUSY);
    if (rst) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      exmem_bubble = 1'b1;
      md_busy      = 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (ex_md_start) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_bubble = 1'b1;
          end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end
        end
        MD_BUSY: begin
          if (md_cnt != 4'd0) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_bubble = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // FSM and MUL/DIV occupancy counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      md_cnt <= 4'd0;
    end else begin
      unique case (state)
        RUN: begin
          if (!ex_branch_taken && ex_md_start) begin
            state  <= MD_BUSY;
            md_cnt <= MD_INIT;
          end
        end
        MD_BUSY: begin
          if (md_cnt != 4'd0) md_cnt <= md_cnt - 4'd1;
          else                state  <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  // Saturating count of cycles with the PC held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (!pc_write && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl.
// Expected control vectors queued at drive, checked at negedge.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ifid_rs, ifid_rt, idex_rt;
  logic        idex_memread, ex_md_start, ex_branch_taken;
  logic        pc_write, ifid_write, ifid_flush, idex_write;
  logic        idex_bubble, exmem_bubble, md_busy;
  logic [15:0] stall_count;
  logic        s_pc, s_ifw, s_fl, s_idw, s_bub, s_exb, s_busy;
  logic [3:0]  s_cnt;

  int checks = 0;
  int errors = 0;

  // order: pc_write ifid_write ifid_flush idex_write idex_bubble exmem_bubble md_busy
  localparam logic [6:0] RSTV = 7'b0010110;
  localparam logic [6:0] DEF  = 7'b1101000;
  localparam logic [6:0] LU   = 7'b0001100;
  localparam logic [6:0] MDR  = 7'b0000010;
  localparam logic [6:0] MDB  = 7'b0000011;
  localparam logic [6:0] REL  = 7'b1101001;
  localparam logic [6:0] BR   = 7'b1111100;

  logic [6:0] sb_q[$];
  string      tag_q[$];

  always #5 clk = ~clk;

  hazard_ctrl u_dut (
    .clk(clk), .rst(rst),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .idex_memread(idex_memread), .idex_rt(idex_rt),
    .ex_md_start(ex_md_start), .ex_branch_taken(ex_branch_taken),
    .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_write(idex_write),
    .idex_bubble(idex_bubble), .exmem_bubble(exmem_bubble),
    .md_busy(md_busy), .stall_count(stall_count)
  );

  hazard_ctrl #(.MD_LATENCY(4), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .idex_memread(idex_memread), .idex_rt(idex_rt),
    .ex_md_start(ex_md_start), .ex_branch_taken(ex_branch_taken),
    .pc_write(s_pc), .ifid_write(s_ifw),
    .ifid_flush(s_fl), .idex_write(s_idw),
    .idex_bubble(s_bub), .exmem_bubble(s_exb),
    .md_busy(s_busy), .stall_count(s_cnt)
  );

  task automatic cmp_out();
    logic [6:0] got, exp;
    string t;
    got = {pc_write, ifid_write, ifid_flush, idex_write,
           idex_bubble, exmem_bubble, md_busy};
    exp = sb_q.pop_front();
    t   = tag_q.pop_front();
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", t, got, exp);
    end
  endtask

  task automatic chk(input string t, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", t, got, exp);
    end
  endtask

  task automatic step(input logic mr, input logic [4:0] rt,
                      input logic [4:0] rs, input logic [4:0] rtf,
                      input logic md, input logic br,
                      input logic [6:0] exp, input string t);
    @(posedge clk);
    #1;
    idex_memread    = mr;
    idex_rt         = rt;
    ifid_rs         = rs;
    ifid_rt         = rtf;
    ex_md_start     = md;
    ex_branch_taken = br;
    sb_q.push_back(exp);
    tag_q.push_back(t);
    @(negedge clk);
    cmp_out();
  endtask

  task automatic idle(input string t);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, DEF, t);
  endtask

  task automatic md_seq(input string t);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, MDR, {t, "_c0"});
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, MDB, {t, "_c1"});
    step(1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b1, MDB, {t, "_c2"});
    step(1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b1, REL, {t, "_c3"});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst             = 1'b1;
    idex_memread    = 1'b1;
    idex_rt         = 5'd7;
    ifid_rs         = 5'd7;
    ifid_rt         = 5'd0;
    ex_md_start     = 1'b1;
    ex_branch_taken = 1'b0;

    // reset state with hazards on the inputs
    @(negedge clk);
    @(negedge clk);
    sb_q.push_back(RSTV);
    tag_q.push_back("reset_out");
    cmp_out();
    chk("reset_cnt", stall_count, 16'd0);
    idex_memread = 1'b0;
    ex_md_start  = 1'b0;
    rst          = 1'b0;
    idle("post_reset");

    // load-use stalls one cycle, rt==0 never stalls
    step(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, LU, "lu_rs");
    idle("lu_release");
    chk("lu_cnt", stall_count, 16'd1);
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, DEF, "lu_rt0");
    step(1'b0, 5'd9, 5'd9, 5'd9, 1'b0, 1'b0, DEF, "no_load");
    step(1'b1, 5'd9, 5'd1, 5'd9, 1'b0, 1'b0, LU, "lu_rt");
    idle("lu_rt_release");
    chk("lu_rt_cnt", stall_count, 16'd2);

    // MUL/DIV occupies EX for four cycles, three stalled
    md_seq("md");
    idle("md_after");
    chk("md_cnt", stall_count, 16'd5);

    // branch beats load-use and MUL/DIV
    step(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b1, BR, "br_lu");
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, BR, "br_md");
    idle("br_after");
    chk("br_cnt", stall_count, 16'd5);

    // async reset while md_cnt==1 abandons the MUL/DIV
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, MDR, "ab_c0");
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, MDB, "ab_c1");
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("ab_busy", {15'd0, md_busy}, 16'd0);
    chk("ab_cnt", stall_count, 16'd0);
    #1;
    rst = 1'b0;
    ex_md_start = 1'b0;
    idle("ab_idle");
    md_seq("rs");
    idle("rs_after");
    chk("rs_cnt", stall_count, 16'd3);

    // saturation on the 4-bit counter
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("sat_reset", {12'd0, s_cnt}, 16'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++)
      step(1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b0, LU, "sat_lu");
    idle("sat_after");
    chk("sat_cnt4", {12'd0, s_cnt}, 16'd15);
    chk("sat_cnt16", stall_count, 16'd20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
